// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage pipeline.
//
// Takes the IF/ID latch (instruction + PC+4), reads the 32x32 register file
// (with write-through bypass from write-back), decodes the control fields,
// sign-extends the immediate and loads everything into the ID/EX latch.
// A load-use hazard unit stalls fetch and inserts a bubble into ID/EX.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   if_id_instr/npc       instruction and PC+4 from fetch
//   ex_mem_pc_src         branch taken in MEM, flushes the ID/EX controls
//   wb_reg_write/_reg/_data   register-file write-back port
//   pc_write, if_id_write     fetch stall controls (combinational)
//   id_ex_*               registered ID/EX latch outputs
//   stall_count           load-use stall counter (only with DECODE_STALL_CNT_EN)
//
// Optional feature macro: DECODE_STALL_CNT_EN
module decode_stage #(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            if_id_instr,
    input  logic [31:0]            if_id_npc,
    input  logic                   ex_mem_pc_src,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_write_reg,
    input  logic [DATA_W-1:0]      wb_write_data,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic [31:0]            id_ex_npc,
    output logic [DATA_W-1:0]      id_ex_rdata1,
    output logic [DATA_W-1:0]      id_ex_rdata2,
    output logic [DATA_W-1:0]      id_ex_imm,
    output logic [4:0]             id_ex_rs,
    output logic [4:0]             id_ex_rt,
    output logic [4:0]             id_ex_rd,
    output logic [1:0]             id_ex_wb,
    output logic [2:0]             id_ex_m,
    output logic [3:0]             id_ex_ex
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              wb_active;
    logic [1:0]        ctl_wb;
    logic [2:0]        ctl_m;
    logic [3:0]        ctl_ex;
    logic              stall;
    logic              bubble;

    assign opcode  = if_id_instr[31:26];
    assign rs      = if_id_instr[25:21];
    assign rt      = if_id_instr[20:16];
    assign rd      = if_id_instr[15:11];
    assign imm_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

    // Writes to r0 are discarded, so r0 never needs special handling on the write side
    assign wb_active = wb_reg_write && (wb_write_reg != 5'd0);

    // Register file storage; write-back is never gated by stall or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_active) begin
            regs[wb_write_reg] <= wb_write_data;
        end
    end

    // Reads bypass the write-back value in the same cycle so a write and a
    // dependent decode can share a cycle without a forwarding hazard
    always_comb begin
        rdata1 = regs[rs];
        rdata2 = regs[rt];
        if (wb_active && (wb_write_reg == rs)) begin
            rdata1 = wb_write_data;
        end
        if (wb_active && (wb_write_reg == rt)) begin
            rdata2 = wb_write_data;
        end
        if (rs == 5'd0) begin
            rdata1 = '0;
        end
        if (rt == 5'd0) begin
            rdata2 = '0;
        end
    end

    // Main control decoder: wb={reg_write,mem_to_reg}, m={branch,mem_read,mem_write},
    // ex={reg_dst,alu_op[1:0],alu_src}; unknown opcodes decode as a NOP
    always_comb begin
        ctl_wb = 2'b00;
        ctl_m  = 3'b000;
        ctl_ex = 4'b0000;
        case (opcode)
            OP_RTYPE: begin ctl_wb = 2'b10; ctl_m = 3'b000; ctl_ex = 4'b1100; end
            OP_LW:    begin ctl_wb = 2'b11; ctl_m = 3'b010; ctl_ex = 4'b0001; end
            OP_SW:    begin ctl_wb = 2'b00; ctl_m = 3'b001; ctl_ex = 4'b0001; end
            OP_BEQ:   begin ctl_wb = 2'b00; ctl_m = 3'b100; ctl_ex = 4'b0010; end
            OP_ADDI:  begin ctl_wb = 2'b10; ctl_m = 3'b000; ctl_ex = 4'b0001; end
            default:  begin ctl_wb = 2'b00; ctl_m = 3'b000; ctl_ex = 4'b0000; end
        endcase
    end

    // Load-use hazard: a load in EX whose destination feeds this instruction
    assign stall = id_ex_m[1] && (id_ex_rt != 5'd0) && ((id_ex_rt == rs) || (id_ex_rt == rt));

    // pc_write stays low on stall even during a flush; fetch gives the branch priority
    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign bubble      = stall || ex_mem_pc_src;

    // ID/EX latch: data fields always load, controls are zeroed for a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_npc    <= '0;
            id_ex_rdata1 <= '0;
            id_ex_rdata2 <= '0;
            id_ex_imm    <= '0;
            id_ex_rs     <= '0;
            id_ex_rt     <= '0;
            id_ex_rd     <= '0;
            id_ex_wb     <= '0;
            id_ex_m      <= '0;
            id_ex_ex     <= '0;
        end else begin
            id_ex_npc    <= if_id_npc;
            id_ex_rdata1 <= rdata1;
            id_ex_rdata2 <= rdata2;
            id_ex_imm    <= imm_ext;
            id_ex_rs     <= rs;
            id_ex_rt     <= rt;
            id_ex_rd     <= rd;
            id_ex_wb     <= bubble ? 2'b00   : ctl_wb;
            id_ex_m      <= bubble ? 3'b000  : ctl_m;
            id_ex_ex     <= bubble ? 4'b0000 : ctl_ex;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    // Counts real load-use stalls only; a stall hidden by a flush is not counted.
    // Saturates rather than wrapping so a long run never reads back as small.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && !ex_mem_pc_src && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
// Inputs are driven just after a rising edge; outputs are sampled 1 ns after
// the next rising edge, or 1 ns after driving for the combinational stall outputs.
module tb_decode_stage;

    logic        clk = 1'b1;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        ex_mem_pc_src;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        pc_write;
    logic        if_id_write;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rdata1;
    logic [31:0] id_ex_rdata2;
    logic [31:0] id_ex_imm;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checkCount = 0;
    int errorCount = 0;
    int expStalls  = 0;

    decode_stage #(.DATA_W(32), .STALL_CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .ex_mem_pc_src (ex_mem_pc_src),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .id_ex_npc     (id_ex_npc),
        .id_ex_rdata1  (id_ex_rdata1),
        .id_ex_rdata2  (id_ex_rdata2),
        .id_ex_imm     (id_ex_imm),
        .id_ex_rs      (id_ex_rs),
        .id_ex_rt      (id_ex_rt),
        .id_ex_rd      (id_ex_rd),
        .id_ex_wb      (id_ex_wb),
        .id_ex_m       (id_ex_m),
        .id_ex_ex      (id_ex_ex)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stall_count   (stall_count)
`endif
    );

    // Rising edges at 10, 20, 30 ... ns
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] npc, input logic pcSrc,
                                 input logic wr, input logic [4:0] wreg, input logic [31:0] wdata);
        if_id_instr   = instr;
        if_id_npc     = npc;
        ex_mem_pc_src = pcSrc;
        wb_reg_write  = wr;
        wb_write_reg  = wreg;
        wb_write_data = wdata;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // lw r8,0(r1) followed by a consumer; checks stall outputs and the bubble
    task automatic loadUsePair(input logic [31:0] useInstr, input logic flush, input logic expectStall);
        applyStimulus(32'h8C28_0000, 32'h0000_0200, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("lu_lw_m", {29'd0, id_ex_m}, 32'h2);
        applyStimulus(useInstr, 32'h0000_0204, flush, 1'b0, 5'd0, 32'h0);
        checkOutput("lu_pc_write", {31'd0, pc_write}, {31'd0, !expectStall});
        checkOutput("lu_if_id_write", {31'd0, if_id_write}, {31'd0, !expectStall});
        if (expectStall && !flush) begin
            expStalls++;
        end
        stepClock();
        checkOutput("lu_bubble_wb", {30'd0, id_ex_wb}, (expectStall || flush) ? 32'h0 : 32'h2);
        checkOutput("lu_bubble_ex", {28'd0, id_ex_ex}, (expectStall || flush) ? 32'h0 : 32'hC);
        ex_mem_pc_src = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        #10;
        checkOutput("rst_wb", {30'd0, id_ex_wb}, 32'h0);
        checkOutput("rst_m", {29'd0, id_ex_m}, 32'h0);
        checkOutput("rst_ex", {28'd0, id_ex_ex}, 32'h0);
        checkOutput("rst_npc", id_ex_npc, 32'h0);
        checkOutput("rst_rdata1", id_ex_rdata1, 32'h0);
        checkOutput("rst_pc_write", {31'd0, pc_write}, 32'h1);
        checkOutput("rst_if_id_write", {31'd0, if_id_write}, 32'h1);
        #4;
        rst = 1'b1;

        // add r3,r1,r2 with a freshly reset register file
        applyStimulus(32'h0022_1820, 32'h0000_0104, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("r1_reads_zero", id_ex_rdata1, 32'h0);
        checkOutput("r2_reads_zero", id_ex_rdata2, 32'h0);
        checkOutput("add_npc", id_ex_npc, 32'h0000_0104);
        checkOutput("add_rd", {27'd0, id_ex_rd}, 32'd3);

        // write r5 while decoding an unknown opcode (NOP controls)
        applyStimulus(32'hFC00_0000, 32'h0000_0108, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        stepClock();
        checkOutput("nop_ex", {28'd0, id_ex_ex}, 32'h0);
        checkOutput("nop_wb", {30'd0, id_ex_wb}, 32'h0);

        // add r7,r5,r6 reads back the stored value
        applyStimulus(32'h00A6_3820, 32'h0000_010C, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("wb_read_r5", id_ex_rdata1, 32'hDEAD_BEEF);
        checkOutput("wb_read_r6", id_ex_rdata2, 32'h0);
        checkOutput("add_rd7", {27'd0, id_ex_rd}, 32'd7);
        checkOutput("add_ex", {28'd0, id_ex_ex}, 32'hC);
        checkOutput("add_wb", {30'd0, id_ex_wb}, 32'h2);

        // addi r10,r9,-4 with r9 written in the same cycle (bypass)
        applyStimulus(32'h212A_FFFC, 32'h0000_0110, 1'b0, 1'b1, 5'd9, 32'h1234_5678);
        stepClock();
        checkOutput("bypass_rdata1", id_ex_rdata1, 32'h1234_5678);
        checkOutput("addi_imm", id_ex_imm, 32'hFFFF_FFFC);
        checkOutput("addi_ex", {28'd0, id_ex_ex}, 32'h1);
        checkOutput("addi_wb", {30'd0, id_ex_wb}, 32'h2);

        // add r8,r9,r0: the bypassed write also landed in the array
        applyStimulus(32'h0120_4020, 32'h0000_0114, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("r9_stored", id_ex_rdata1, 32'h1234_5678);

        // sw r2,4(r1) under flush, with an attempted write to r0
        applyStimulus(32'hAC22_0004, 32'h0000_0118, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        stepClock();
        checkOutput("flush_m", {29'd0, id_ex_m}, 32'h0);
        checkOutput("flush_wb", {30'd0, id_ex_wb}, 32'h0);
        checkOutput("flush_ex", {28'd0, id_ex_ex}, 32'h0);
        checkOutput("flush_imm", id_ex_imm, 32'h4);
        checkOutput("flush_rt", {27'd0, id_ex_rt}, 32'd2);
        applyStimulus(32'h0000_0000, 32'h0000_011C, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("r0_still_zero", id_ex_rdata1, 32'h0);

        // load-use: rs match, then the held add decodes normally
        loadUsePair(32'h0103_1020, 1'b0, 1'b1);
        checkOutput("after_bubble_pc_write", {31'd0, pc_write}, 32'h1);
        stepClock();
        checkOutput("add_after_stall_ex", {28'd0, id_ex_ex}, 32'hC);
        checkOutput("add_after_stall_wb", {30'd0, id_ex_wb}, 32'h2);
        checkOutput("add_after_stall_rd", {27'd0, id_ex_rd}, 32'd2);

        // load-use via rt match, then another rs match
        loadUsePair(32'h0068_1020, 1'b0, 1'b1);
        loadUsePair(32'h0103_1020, 1'b0, 1'b1);
`ifdef DECODE_STALL_CNT_EN
        checkOutput("stall_count_3", {16'd0, stall_count}, expStalls);
`endif
        // stall coincident with a flush: bubble, pc_write low, not counted
        loadUsePair(32'h0103_1020, 1'b1, 1'b1);
`ifdef DECODE_STALL_CNT_EN
        checkOutput("stall_count_flush", {16'd0, stall_count}, expStalls);
`endif

        // load into r0 never causes a stall
        applyStimulus(32'h8C20_0000, 32'h0000_0300, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        applyStimulus(32'h0000_1020, 32'h0000_0304, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("lw_r0_no_stall", {31'd0, pc_write}, 32'h1);

        // reset mid-operation clears latch and register file immediately
        rst = 1'b0;
        #1;
        checkOutput("midrst_m", {29'd0, id_ex_m}, 32'h0);
        checkOutput("midrst_npc", id_ex_npc, 32'h0);
`ifdef DECODE_STALL_CNT_EN
        checkOutput("midrst_count", {16'd0, stall_count}, 32'h0);
`endif
        #2;
        rst = 1'b1;
        applyStimulus(32'h00A6_3820, 32'h0000_0400, 1'b0, 1'b0, 5'd0, 32'h0);
        stepClock();
        checkOutput("midrst_r5_cleared", id_ex_rdata1, 32'h0);
        checkOutput("midrst_first_decode_ex", {28'd0, id_ex_ex}, 32'hC);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no summary expected summary before 100us");
        $fatal(1, "[TB] timeout");
    end

endmodule
